// File: rtl/mopshub_clk_pkg.sv
// rtl/mopshub_clk_pkg.sv - shared types and defaults for the clock-forwarding lock controller
// Purpose : FSM state encoding, default parameter values and the saturating
//           status-counter helper used by clk_fwd_lock_ctrl.
// Ports   : none (package).
// Option  : LOCK_STATUS_CNT_EN enables the status counters that use sat_inc.
package mopshub_clk_pkg;

   localparam int STATE_W            = 2;
   localparam int DEF_LOCK_CYCLES    = 1024;
   localparam int DEF_TIMEOUT_CYCLES = 65536;
   localparam int DEF_RST_CYCLES     = 16;
   localparam int DEF_CNT_W          = 17;
   localparam int STAT_CNT_W         = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_RST_MMCM  = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
      return (v == '1) ? v : v + STAT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/clk_fwd_lock_ctrl_if.sv
// rtl/clk_fwd_lock_ctrl_if.sv - signal bundle between the lock controller and its environment
// Purpose : groups the MMCM status/control and forwarding-enable signals.
// Signals : mmcm_locked (raw, async), force_relock, mmcm_rst, fwd_en,
//           lol_pulse, timeout_pulse, state_o[1:0];
//           lol_count[7:0], relock_count[7:0] only with LOCK_STATUS_CNT_EN.
// Modports: master = environment side, slave = controller side.
interface clk_fwd_lock_ctrl_if;
   import mopshub_clk_pkg::*;

   logic                  mmcm_locked;
   logic                  force_relock;
   logic                  mmcm_rst;
   logic                  fwd_en;
   logic                  lol_pulse;
   logic                  timeout_pulse;
   logic [STATE_W-1:0]    state_o;
`ifdef LOCK_STATUS_CNT_EN
   logic [STAT_CNT_W-1:0] lol_count;
   logic [STAT_CNT_W-1:0] relock_count;

   modport master (output mmcm_locked, force_relock,
                   input  mmcm_rst, fwd_en, lol_pulse, timeout_pulse, state_o,
                          lol_count, relock_count);
   modport slave  (input  mmcm_locked, force_relock,
                   output mmcm_rst, fwd_en, lol_pulse, timeout_pulse, state_o,
                          lol_count, relock_count);
`else
   modport master (output mmcm_locked, force_relock,
                   input  mmcm_rst, fwd_en, lol_pulse, timeout_pulse, state_o);
   modport slave  (input  mmcm_locked, force_relock,
                   output mmcm_rst, fwd_en, lol_pulse, timeout_pulse, state_o);
`endif
endinterface

// File: rtl/clk_fwd_lock_ctrl_sync_2ff.sv
// rtl/clk_fwd_lock_ctrl_sync_2ff.sv - generic two-flop synchronizer
// Purpose : brings an asynchronous level into the clk domain, 2-cycle latency.
// Ports   : clk, rst (sync, active-low, clears both flops),
//           i_d[WIDTH-1:0] async input, o_q[WIDTH-1:0] synchronized output.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/clk_fwd_lock_ctrl.sv
// rtl/clk_fwd_lock_ctrl.sv - MMCM lock qualification and forwarded-clock enable
// Purpose : filters the MMCM locked flag, drives fwd_en for the clock
//           forwarding stage and pulses the MMCM reset for automatic re-lock.
// Ports   : clk (free-running), rst (sync, active-low),
//           bus (clk_fwd_lock_ctrl_if.slave): mmcm_locked, force_relock in;
//           mmcm_rst, fwd_en, lol_pulse, timeout_pulse, state_o out.
// Option  : LOCK_STATUS_CNT_EN adds saturating lol_count / relock_count.
module clk_fwd_lock_ctrl
   import mopshub_clk_pkg::*;
#(
   parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int RST_CYCLES     = DEF_RST_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   clk_fwd_lock_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_lol_nxt;
   logic             w_tmo_nxt;
   logic             w_locked_s;
   logic             r_mmcm_rst;
   logic             r_fwd_en;
   logic             r_lol_pulse;
   logic             r_tmo_pulse;

   sync_2ff #(.WIDTH(1)) u_sync_locked (
      .clk (clk),
      .rst (rst),
      .i_d (bus.mmcm_locked),
      .o_q (w_locked_s)
   );

   // One counter serves all states: reset-pulse width, lock timeout and
   // qualification length. Every terminal value leaves the state or holds.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lol_nxt   = 1'b0;
      w_tmo_nxt   = 1'b0;
      if (bus.force_relock && (r_state != ST_RST_MMCM)) begin
         // Manual relock wins over lock loss and timeout, so no pulses.
         w_state_nxt = ST_RST_MMCM;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_RST_MMCM: begin
               if (r_cnt == RST_LAST) begin
                  w_state_nxt = ST_WAIT_LOCK;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (w_locked_s) begin
                  w_state_nxt = ST_STABLE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == TMO_LAST) begin
                  w_state_nxt = ST_RST_MMCM;
                  w_cnt_nxt   = '0;
                  w_tmo_nxt   = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_STABLE: begin
               if (!w_locked_s) begin
                  w_state_nxt = ST_WAIT_LOCK;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == LOCK_LAST) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!w_locked_s) begin
                  w_state_nxt = ST_WAIT_LOCK;
                  w_cnt_nxt   = '0;
                  w_lol_nxt   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_RST_MMCM;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they change on the
   // same edge as the state itself.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_RST_MMCM;
         r_cnt       <= '0;
         r_mmcm_rst  <= 1'b1;
         r_fwd_en    <= 1'b0;
         r_lol_pulse <= 1'b0;
         r_tmo_pulse <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_mmcm_rst  <= (w_state_nxt == ST_RST_MMCM);
         r_fwd_en    <= (w_state_nxt == ST_RUN);
         r_lol_pulse <= w_lol_nxt;
         r_tmo_pulse <= w_tmo_nxt;
      end
   end

   assign bus.mmcm_rst      = r_mmcm_rst;
   assign bus.fwd_en        = r_fwd_en;
   assign bus.lol_pulse     = r_lol_pulse;
   assign bus.timeout_pulse = r_tmo_pulse;
   assign bus.state_o       = r_state;

`ifdef LOCK_STATUS_CNT_EN
   logic [STAT_CNT_W-1:0] r_lol_count;
   logic [STAT_CNT_W-1:0] r_relock_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lol_count    <= '0;
         r_relock_count <= '0;
      end else begin
         if (w_lol_nxt) r_lol_count    <= sat_inc(r_lol_count);
         if (w_tmo_nxt) r_relock_count <= sat_inc(r_relock_count);
      end
   end

   assign bus.lol_count    = r_lol_count;
   assign bus.relock_count = r_relock_count;
`endif

endmodule

// File: tb/tb_clk_fwd_lock_ctrl.sv
// tb/tb_clk_fwd_lock_ctrl.sv - self-checking bench for clk_fwd_lock_ctrl
module tb_clk_fwd_lock_ctrl;

   localparam int LOCK_C = 8;
   localparam int TMO_C  = 32;
   localparam int RST_C  = 16;

   localparam int EV_MRST = 0;
   localparam int EV_FWD  = 1;
   localparam int EV_LOL  = 2;
   localparam int EV_TMO  = 3;

   typedef struct {
      int kind;
      int val;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   mon_en = 1'b0;
   logic p_mrst = 1'b1;
   logic p_fwd  = 1'b0;
   ev_t  sb[$];
   ev_t  obs_q[$];
   int   m_idx;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   clk_fwd_lock_ctrl_if bus();

   clk_fwd_lock_ctrl #(
      .LOCK_CYCLES    (LOCK_C),
      .TIMEOUT_CYCLES (TMO_C),
      .RST_CYCLES     (RST_C),
      .CNT_W          (17)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Output-event monitor: every edge of mmcm_rst/fwd_en and every cycle a
   // pulse is high must match an expected event in the scoreboard.
   always @(negedge clk) begin
      obs_q.delete();
      if (bus.mmcm_rst !== p_mrst) obs_q.push_back('{EV_MRST, int'(bus.mmcm_rst), cyc});
      if (bus.fwd_en !== p_fwd)    obs_q.push_back('{EV_FWD, int'(bus.fwd_en), cyc});
      if (bus.lol_pulse === 1'b1)     obs_q.push_back('{EV_LOL, 1, cyc});
      if (bus.timeout_pulse === 1'b1) obs_q.push_back('{EV_TMO, 1, cyc});
      p_mrst = bus.mmcm_rst;
      p_fwd  = bus.fwd_en;
      if (mon_en) begin
         foreach (obs_q[i]) begin
            m_idx = -1;
            for (int j = 0; j < sb.size(); j++)
               if (m_idx < 0 && sb[j].kind == obs_q[i].kind) m_idx = j;
            n_checks++;
            if (m_idx < 0) begin
               n_errors++;
               $display("FAIL unexpected_event: kind=%0d val=%0d at cycle %0d, none expected",
                        obs_q[i].kind, obs_q[i].val, obs_q[i].cyc);
            end else begin
               if (sb[m_idx].val != obs_q[i].val || sb[m_idx].cyc != obs_q[i].cyc) begin
                  n_errors++;
                  $display("FAIL event_kind%0d: got val=%0d cycle=%0d, expected val=%0d cycle=%0d",
                           obs_q[i].kind, obs_q[i].val, obs_q[i].cyc, sb[m_idx].val, sb[m_idx].cyc);
               end
               sb.delete(m_idx);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at_cyc(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic expect_ev(input int kind, input int val, input int c);
      sb.push_back('{kind, val, c});
   endtask

   task automatic after_negedge();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      int k;
      mon_en = 1'b0;
      bus.mmcm_locked  = 1'b0;
      bus.force_relock = 1'b0;
      rst = 1'b0;
      step(1);
      n_checks++;
      if (bus.fwd_en !== 1'b0 || bus.mmcm_rst !== 1'b1 || bus.state_o !== 2'd0 ||
          bus.lol_pulse !== 1'b0 || bus.timeout_pulse !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: fwd_en=%b mmcm_rst=%b state=%0d lol=%b tmo=%b, expected 0 1 0 0 0",
                  bus.fwd_en, bus.mmcm_rst, bus.state_o, bus.lol_pulse, bus.timeout_pulse);
      end
      step(2);
`ifdef LOCK_STATUS_CNT_EN
      n_checks++;
      if (bus.lol_count !== 8'd0 || bus.relock_count !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_counts: lol=%0d relock=%0d, expected 0 0", bus.lol_count, bus.relock_count);
      end
`endif
      sb.delete();
      rst = 1'b1;
      k = cyc;
      after_negedge();
      mon_en = 1'b1;
      expect_ev(EV_MRST, 0, k + RST_C);
      at_cyc(k + RST_C - 1);
      n_checks++;
      if (bus.mmcm_rst !== 1'b1 || bus.state_o !== 2'd0) begin
         n_errors++;
         $display("FAIL rst_pulse_width: mmcm_rst=%b state=%0d at last pulse cycle, expected 1 0",
                  bus.mmcm_rst, bus.state_o);
      end
      at_cyc(k + RST_C);
      n_checks++;
      if (bus.mmcm_rst !== 1'b0 || bus.state_o !== 2'd1) begin
         n_errors++;
         $display("FAIL rst_pulse_end: mmcm_rst=%b state=%0d, expected 0 1", bus.mmcm_rst, bus.state_o);
      end
      after_negedge();
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL reset_missing_events: %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_lock();
      int c = cyc;
      bus.mmcm_locked = 1'b1;
      expect_ev(EV_FWD, 1, c + LOCK_C + 3);
      at_cyc(c + LOCK_C + 2);
      n_checks++;
      if (bus.fwd_en !== 1'b0 || bus.state_o !== 2'd2) begin
         n_errors++;
         $display("FAIL lock_early: fwd_en=%b state=%0d, expected 0 2", bus.fwd_en, bus.state_o);
      end
      at_cyc(c + LOCK_C + 3);
      n_checks++;
      if (bus.fwd_en !== 1'b1 || bus.state_o !== 2'd3) begin
         n_errors++;
         $display("FAIL lock_run: fwd_en=%b state=%0d, expected 1 3", bus.fwd_en, bus.state_o);
      end
      after_negedge();
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL lock_missing_events: %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_glitch();
      int c = cyc;
      bus.mmcm_locked = 1'b0;
      step(1);
      bus.mmcm_locked = 1'b1;
      expect_ev(EV_FWD, 0, c + 3);
      expect_ev(EV_LOL, 1, c + 3);
      expect_ev(EV_FWD, 1, c + 1 + LOCK_C + 3);
      at_cyc(c + 3);
      n_checks++;
      if (bus.fwd_en !== 1'b0 || bus.lol_pulse !== 1'b1 || bus.state_o !== 2'd1) begin
         n_errors++;
         $display("FAIL glitch_loss: fwd_en=%b lol=%b state=%0d, expected 0 1 1",
                  bus.fwd_en, bus.lol_pulse, bus.state_o);
      end
      at_cyc(c + 1 + LOCK_C + 3);
      n_checks++;
      if (bus.fwd_en !== 1'b1 || bus.state_o !== 2'd3) begin
         n_errors++;
         $display("FAIL glitch_relock: fwd_en=%b state=%0d, expected 1 3", bus.fwd_en, bus.state_o);
      end
      after_negedge();
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL glitch_missing_events: %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_timeout();
      int c = cyc;
      int w1;
      int w2;
      bus.mmcm_locked = 1'b0;
      w1 = c + 3;
      w2 = w1 + TMO_C + RST_C;
      expect_ev(EV_FWD, 0, c + 3);
      expect_ev(EV_LOL, 1, c + 3);
      expect_ev(EV_TMO, 1, w1 + TMO_C);
      expect_ev(EV_MRST, 1, w1 + TMO_C);
      expect_ev(EV_MRST, 0, w1 + TMO_C + RST_C);
      expect_ev(EV_TMO, 1, w2 + TMO_C);
      expect_ev(EV_MRST, 1, w2 + TMO_C);
      expect_ev(EV_MRST, 0, w2 + TMO_C + RST_C);
      at_cyc(w1 + TMO_C);
      n_checks++;
      if (bus.timeout_pulse !== 1'b1 || bus.state_o !== 2'd0 || bus.mmcm_rst !== 1'b1) begin
         n_errors++;
         $display("FAIL timeout_first: tmo=%b state=%0d mmcm_rst=%b, expected 1 0 1",
                  bus.timeout_pulse, bus.state_o, bus.mmcm_rst);
      end
      step(1);
      n_checks++;
      if (bus.timeout_pulse !== 1'b0) begin
         n_errors++;
         $display("FAIL timeout_pulse_width: tmo=%b one cycle later, expected 0", bus.timeout_pulse);
      end
      at_cyc(w2 + TMO_C + RST_C);
      n_checks++;
      if (bus.state_o !== 2'd1 || bus.mmcm_rst !== 1'b0) begin
         n_errors++;
         $display("FAIL timeout_repeat: state=%0d mmcm_rst=%b, expected 1 0", bus.state_o, bus.mmcm_rst);
      end
      after_negedge();
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL timeout_missing_events: %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_stable_glitch();
      int d = cyc;
      bus.mmcm_locked = 1'b1;
      at_cyc(d + 7);
      n_checks++;
      if (bus.state_o !== 2'd2) begin
         n_errors++;
         $display("FAIL stable_entry: state=%0d, expected 2", bus.state_o);
      end
      bus.mmcm_locked = 1'b0;
      step(1);
      bus.mmcm_locked = 1'b1;
      expect_ev(EV_FWD, 1, d + 8 + LOCK_C + 3);
      at_cyc(d + 10);
      n_checks++;
      if (bus.state_o !== 2'd1 || bus.fwd_en !== 1'b0) begin
         n_errors++;
         $display("FAIL stable_drop: state=%0d fwd_en=%b, expected 1 0", bus.state_o, bus.fwd_en);
      end
      at_cyc(d + 8 + LOCK_C + 2);
      n_checks++;
      if (bus.fwd_en !== 1'b0) begin
         n_errors++;
         $display("FAIL stable_restart: fwd_en=%b one cycle before full requalification, expected 0", bus.fwd_en);
      end
      at_cyc(d + 8 + LOCK_C + 3);
      n_checks++;
      if (bus.state_o !== 2'd3) begin
         n_errors++;
         $display("FAIL stable_run: state=%0d, expected 3", bus.state_o);
      end
      after_negedge();
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL stable_missing_events: %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_force();
      int c = cyc;
      bus.mmcm_locked = 1'b0;
      expect_ev(EV_FWD, 0, c + 3);
      expect_ev(EV_MRST, 1, c + 3);
      expect_ev(EV_MRST, 0, c + 3 + RST_C);
      at_cyc(c + 2);
      bus.force_relock = 1'b1;
      step(1);
      bus.force_relock = 1'b0;
      n_checks++;
      if (bus.state_o !== 2'd0 || bus.lol_pulse !== 1'b0 || bus.fwd_en !== 1'b0) begin
         n_errors++;
         $display("FAIL force_override: state=%0d lol=%b fwd_en=%b, expected 0 0 0",
                  bus.state_o, bus.lol_pulse, bus.fwd_en);
      end
      at_cyc(c + 10);
      bus.force_relock = 1'b1;
      step(1);
      bus.force_relock = 1'b0;
      at_cyc(c + 3 + RST_C);
      n_checks++;
      if (bus.state_o !== 2'd1 || bus.mmcm_rst !== 1'b0) begin
         n_errors++;
         $display("FAIL force_in_rst_ignored: state=%0d mmcm_rst=%b, expected 1 0", bus.state_o, bus.mmcm_rst);
      end
      step(1);
      bus.mmcm_locked = 1'b1;
      expect_ev(EV_FWD, 1, cyc + LOCK_C + 3);
      at_cyc(cyc + LOCK_C + 3);
      n_checks++;
      if (bus.state_o !== 2'd3) begin
         n_errors++;
         $display("FAIL force_relock_run: state=%0d, expected 3", bus.state_o);
      end
      after_negedge();
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL force_missing_events: %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

`ifdef LOCK_STATUS_CNT_EN
   task automatic test_status_counts();
      int c;
      n_checks++;
      if (bus.lol_count !== 8'd2 || bus.relock_count !== 8'd2) begin
         n_errors++;
         $display("FAIL status_counts: lol=%0d relock=%0d, expected 2 2", bus.lol_count, bus.relock_count);
      end
      for (int i = 0; i < 300; i++) begin
         c = cyc;
         bus.mmcm_locked = 1'b0;
         step(1);
         bus.mmcm_locked = 1'b1;
         expect_ev(EV_FWD, 0, c + 3);
         expect_ev(EV_LOL, 1, c + 3);
         expect_ev(EV_FWD, 1, c + 1 + LOCK_C + 3);
         at_cyc(c + 1 + LOCK_C + 3);
      end
      after_negedge();
      n_checks++;
      if (bus.lol_count !== 8'd255 || bus.relock_count !== 8'd2) begin
         n_errors++;
         $display("FAIL status_saturate: lol=%0d relock=%0d, expected 255 2", bus.lol_count, bus.relock_count);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL status_missing_events: %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask
`endif

   initial begin
      bus.mmcm_locked  = 1'b0;
      bus.force_relock = 1'b0;
      rst = 1'b0;
      test_reset();
      test_lock();
      test_glitch();
      test_timeout();
      test_stable_glitch();
      test_force();
`ifdef LOCK_STATUS_CNT_EN
      test_status_counts();
`endif
      test_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clk_fwd_lock_ctrl.md
Name: clk_fwd_lock_ctrl

Overview:
Lock-qualification controller that sits directly upstream of the differential clock-forwarding stage. It watches the clock generator's (MMCM) raw `locked` flag, filters it, and produces the quasi-static enable that gates the forwarded clock. It also drives the MMCM reset for automatic re-lock after a timeout or on request. Runs on the free-running system clock; `mmcm_locked` is asynchronous to it.

Parameters:
LOCK_CYCLES, 1024, consecutive synchronized-locked cycles required before enabling the forwarded clock (>=2).
TIMEOUT_CYCLES, 65536, cycles to wait for lock before re-issuing MMCM reset (>=2).
RST_CYCLES, 16, width of the MMCM reset pulse in cycles (>=1).
CNT_W, 17, shared counter width; must hold max(LOCK_CYCLES, TIMEOUT_CYCLES, RST_CYCLES)-1.

Ports:
clk  in  1  free-running system clock.
rst  in  1  synchronous, active-low reset.
mmcm_locked  in  1  raw MMCM locked flag, asynchronous.
force_relock  in  1  single-cycle request to reset the MMCM and re-qualify lock.
mmcm_rst  out  1  active-high MMCM reset.
fwd_en  out  1  enable for the clock-forwarding stage; feeds its `locked` input.
lol_pulse  out  1  one-cycle pulse on each loss of lock while in RUN.
timeout_pulse  out  1  one-cycle pulse when a lock wait times out.
state_o  out  2  current FSM state code.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=RST_MMCM, cnt=0, sync FFs=0.
  - mmcm_rst=1, fwd_en=0, lol_pulse=0, timeout_pulse=0.
- Synchronizer: 2-FF chain on `mmcm_locked` -> `locked_s`; 2-cycle latency. All FSM decisions use `locked_s` only.
- State codes: RST_MMCM=0, WAIT_LOCK=1, STABLE=2, RUN=3. All outputs are registered.
- RST_MMCM:
  - mmcm_rst=1; cnt increments each cycle.
  - At cnt==RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
  - Pulse width is exactly RST_CYCLES cycles, counted from the first edge with rst=1.
- WAIT_LOCK:
  - mmcm_rst=0.
  - If locked_s=1: go to STABLE, cnt=0.
  - Else, at cnt==TIMEOUT_CYCLES-1: go to RST_MMCM, cnt=0, timeout_pulse=1 for one cycle.
  - Otherwise cnt++.
- STABLE:
  - If locked_s=0: go to WAIT_LOCK, cnt=0. Any glitch restarts qualification.
  - Else, at cnt==LOCK_CYCLES-1: go to RUN.
  - Otherwise cnt++.
- RUN:
  - fwd_en=1; cnt is held.
  - If locked_s=0: go to WAIT_LOCK, cnt=0, fwd_en=0 on the same edge, lol_pulse=1 for one cycle.
- Latency:
  - `mmcm_locked` high (first sampling edge) to fwd_en=1: exactly LOCK_CYCLES+3 edges.
  - `mmcm_locked` low to fwd_en=0: 3 edges.
- fwd_en is high only in RUN. It is a level that changes rarely; the forwarding stage samples it as a clock enable and tolerates the asynchronous crossing.
- Simultaneous events:
  - force_relock=1 in any state except RST_MMCM: go to RST_MMCM, cnt=0, fwd_en=0. It overrides locked_s and timeout handling, and suppresses lol_pulse/timeout_pulse in that cycle.
  - force_relock during RST_MMCM is ignored; the pulse is not extended.
- Reset mid-operation: any state returns to the reset values above. fwd_en drops on the reset edge.
- Counter never wraps; every terminal compare forces a state change or a hold.

Optional Feature:
LOCK_STATUS_CNT_EN
- Defined:
  - Adds output `lol_count [7:0]`, an 8-bit counter of lol_pulse events.
  - Saturates at 255; cleared only by rst.
  - Adds output `relock_count [7:0]`, counting timeout_pulse events, with the same rules.
- Undefined: neither port nor its logic exists.

Decomposition:
- Package `mopshub_clk_pkg`:
  - State enum/localparams (RST_MMCM..RUN) and STATE_W=2.
  - Default parameter values.
  - Status counter width 8.
- One sub-module, `sync_2ff`: generic 2-flop synchronizer with reset to 0. Reused for `mmcm_locked`.

Test Plan:
1. Release rst with mmcm_locked=0 -> mmcm_rst=1 for exactly 16 cycles, then state_o=1.
2. Raise mmcm_locked after reset pulse, LOCK_CYCLES=8 -> fwd_en=1 exactly 11 edges later; state_o=3.
3. In RUN, drop mmcm_locked for 1 cycle -> fwd_en=0 and lol_pulse=1 3 edges later; re-qualifies, fwd_en=1 again 11 edges after the locked return.
4. Keep mmcm_locked=0, TIMEOUT_CYCLES=32 -> timeout_pulse=1 after 32 cycles in WAIT_LOCK, then a new 16-cycle mmcm_rst pulse; repeats.
5. Toggle mmcm_locked during STABLE at cnt=5 -> back to WAIT_LOCK, fwd_en never asserted, counter restarts from 0.
6. Assert force_relock in RUN on the same cycle locked_s falls -> state RST_MMCM, no lol_pulse, fwd_en=0 next edge; with LOCK_STATUS_CNT_EN, 300 loss events -> lol_count=255.
